// File: rtl/cnn_fmap_window_gen_if.sv
// Pixel-in / window-out bundle for the fmap window generator.
// master drives pixels (producer side); slave is the generator.
interface cnn_fmap_window_gen_if #(
  parameter int unsigned CI      = 3,
  parameter int unsigned KX      = 3,
  parameter int unsigned KY      = 3,
  parameter int unsigned I_FM_BW = 8
);
  logic                          i_soft_reset;
  logic [CI*I_FM_BW-1:0]         i_in_pix;
  logic                          i_in_valid;
  logic [CI*KX*KY*I_FM_BW-1:0]   o_ot_fmap;
  logic                          o_ot_valid;
  logic                          o_frame_done;

  modport master (
    output i_soft_reset, i_in_pix, i_in_valid,
    input  o_ot_fmap, o_ot_valid, o_frame_done
  );

  modport slave (
    input  i_soft_reset, i_in_pix, i_in_valid,
    output o_ot_fmap, o_ot_valid, o_frame_done
  );
endinterface

// File: rtl/cnn_fmap_window_gen.sv
// Streaming KXxKYxCI convolution window generator (stride 1, no padding).
// Line buffers hold the previous KY-1 rows; a KX-column shift register forms the window.
module cnn_fmap_window_gen #(
  parameter int unsigned CI      = 3,
  parameter int unsigned KX      = 3,
  parameter int unsigned KY      = 3,
  parameter int unsigned I_FM_BW = 8,
  parameter int unsigned IMG_W   = 8,
  parameter int unsigned IMG_H   = 8
) (
  input logic                  clk,
  input logic                  reset,
  cnn_fmap_window_gen_if.slave bus
);
  localparam int unsigned PixW = CI * I_FM_BW;
  localparam int unsigned FmW  = PixW * KX * KY;
  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_W - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(KX - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(IMG_H - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(KY - 1);

  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;
  logic [PixW-1:0] lb_q [KY-1][IMG_W];
  logic [PixW-1:0] col_vec [KY];
  logic [FmW-1:0]  fmap_q, fmap_d;
  logic            valid_q, done_q;
  logic            accept, in_window, last_pix;

  always_comb begin
    accept    = bus.i_in_valid & ~bus.i_soft_reset;
    in_window = (row_q >= RowFirst) && (col_q >= ColFirst);
    last_pix  = (row_q == RowLast) && (col_q == ColLast);
  end

  // Column vector: oldest rows from the line buffer, newest row from the input.
  always_comb begin
    for (int unsigned ky = 0; ky < KY; ky++) begin
      col_vec[ky] = '0;
    end
    for (int unsigned ky = 0; ky + 1 < KY; ky++) begin
      col_vec[ky] = lb_q[ky][col_q];
    end
    col_vec[KY-1] = bus.i_in_pix;
  end

  // Shift the window one column toward kx=0 and load the new column at kx=KX-1.
  always_comb begin
    fmap_d = fmap_q;
    for (int unsigned ci = 0; ci < CI; ci++) begin
      for (int unsigned ky = 0; ky < KY; ky++) begin
        for (int unsigned kx = 0; kx < KX; kx++) begin
          if (kx + 1 < KX) begin
            fmap_d[((ci*KY+ky)*KX+kx)*I_FM_BW +: I_FM_BW] =
                fmap_q[((ci*KY+ky)*KX+kx+1)*I_FM_BW +: I_FM_BW];
          end else begin
            fmap_d[((ci*KY+ky)*KX+kx)*I_FM_BW +: I_FM_BW] =
                col_vec[ky][ci*I_FM_BW +: I_FM_BW];
          end
        end
      end
    end
  end

  // Line buffer needs no reset: every entry is rewritten before it is read into a valid window.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k + 2 < KY; k++) begin
        lb_q[k][col_q] <= lb_q[k+1][col_q];
      end
      lb_q[KY-2][col_q] <= bus.i_in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      fmap_q  <= '0;
    end else if (bus.i_soft_reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= accept && in_window;
      done_q  <= accept && last_pix;
      if (accept) begin
        fmap_q <= fmap_d;
        if (col_q == ColLast) begin
          col_q <= '0;
          row_q <= (row_q == RowLast) ? '0 : row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
      end
    end
  end

  assign bus.o_ot_fmap    = fmap_q;
  assign bus.o_ot_valid   = valid_q;
  assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_cnn_fmap_window_gen.sv
// Directed and randomized checks of cnn_fmap_window_gen against a frame-image reference model.
module tb_cnn_fmap_window_gen;
  localparam int CI      = 3;
  localparam int KX      = 3;
  localparam int KY      = 3;
  localparam int I_FM_BW = 8;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int PixW    = CI * I_FM_BW;
  localparam int FmW     = PixW * KX * KY;
  localparam int NPix    = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cnn_fmap_window_gen_if #(.CI(CI), .KX(KX), .KY(KY), .I_FM_BW(I_FM_BW)) bus ();

  cnn_fmap_window_gen #(
    .CI(CI), .KX(KX), .KY(KY), .I_FM_BW(I_FM_BW), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: the current frame as an image, plus the raster position of the next pixel.
  logic [PixW-1:0] img [IMG_H][IMG_W];
  int              mrow = 0, mcol = 0;
  logic [FmW-1:0]  exp_fmap = '0;
  logic            exp_valid = 1'b0, exp_done = 1'b0, fmap_known = 1'b0;
  int              obs_win = 0;

  task automatic chk(input string tag, input logic [FmW-1:0] obs, input logic [FmW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PixW-1:0] det_pix(input int r, input int c);
    logic [PixW-1:0] v;
    for (int ci = 0; ci < CI; ci++) v[ci*I_FM_BW +: I_FM_BW] = 8'(ci*64 + r*8 + c);
    return v;
  endfunction

  task automatic model(input logic v, input logic [PixW-1:0] p, input logic sr, input logic rst);
    if (rst) begin
      mrow = 0; mcol = 0; exp_valid = 0; exp_done = 0; exp_fmap = '0; fmap_known = 1;
    end else if (sr) begin
      mrow = 0; mcol = 0; exp_valid = 0; exp_done = 0;
    end else if (v) begin
      img[mrow][mcol] = p;
      exp_valid = (mrow >= KY-1) && (mcol >= KX-1);
      exp_done  = (mrow == IMG_H-1) && (mcol == IMG_W-1);
      if (exp_valid) begin
        for (int ci = 0; ci < CI; ci++)
          for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
              exp_fmap[((ci*KY+ky)*KX+kx)*I_FM_BW +: I_FM_BW] =
                  img[mrow-KY+1+ky][mcol-KX+1+kx][ci*I_FM_BW +: I_FM_BW];
      end
      fmap_known = exp_valid;
      mcol++;
      if (mcol == IMG_W) begin
        mcol = 0;
        mrow = (mrow == IMG_H-1) ? 0 : mrow + 1;
      end
    end else begin
      exp_valid = 0; exp_done = 0;
    end
  endtask

  task automatic step(input logic v, input logic [PixW-1:0] p, input logic sr, input logic rst);
    @(negedge clk);
    bus.i_in_valid   = v;
    bus.i_in_pix     = p;
    bus.i_soft_reset = sr;
    reset            = rst;
    @(posedge clk);
    model(v, p, sr, rst);
    #1;
    chk("valid", FmW'(bus.o_ot_valid), FmW'(exp_valid));
    chk("frame_done", FmW'(bus.o_frame_done), FmW'(exp_done));
    if (fmap_known) chk("fmap", bus.o_ot_fmap, exp_fmap);
    if (bus.o_ot_valid) obs_win++;
  endtask

  logic [71:0] want_ci0;
  int          first_vals [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
  int          last_vals  [9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
  int          accepted;
  logic        v_r;

  initial begin
    bus.i_in_valid   = 1'b0;
    bus.i_in_pix     = '0;
    bus.i_soft_reset = 1'b0;

    // Reset state
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);

    // Basic frame, continuous valid
    obs_win = 0;
    for (int i = 0; i < NPix; i++) begin
      step(1, det_pix(mrow, mcol), 0, 0);
      if (i == 2*IMG_W + 1) chk("no_window_before_2_2", FmW'(obs_win), FmW'(0));
      if (i == 2*IMG_W + 2) begin
        chk("first_valid", FmW'(bus.o_ot_valid), FmW'(1));
        for (int k = 0; k < 9; k++) want_ci0[k*8 +: 8] = 8'(first_vals[k]);
        chk("first_ci0", FmW'(bus.o_ot_fmap[71:0]), FmW'(want_ci0));
        chk("first_ci2_bit144", FmW'(bus.o_ot_fmap[144 +: 8]), FmW'(128));
      end
      if (i == NPix - 1) begin
        for (int k = 0; k < 9; k++) want_ci0[k*8 +: 8] = 8'(last_vals[k]);
        chk("last_ci0", FmW'(bus.o_ot_fmap[71:0]), FmW'(want_ci0));
        chk("last_done", FmW'(bus.o_frame_done), FmW'(1));
      end
    end
    chk("frame_count", FmW'(obs_win), FmW'(36));
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);

    // Two frames back to back with random gaps and random pixels
    obs_win  = 0;
    accepted = 0;
    while (accepted < 2*NPix) begin
      v_r = 1'($urandom_range(0, 1));
      step(v_r, PixW'($urandom), 0, 0);
      if (v_r) accepted++;
    end
    step(0, '0, 0, 0);
    chk("random_count", FmW'(obs_win), FmW'(72));

    // Soft reset coincident with the pixel at (4,5)
    for (int i = 0; i < 4*IMG_W + 5; i++) step(1, det_pix(mrow, mcol), 0, 0);
    step(1, det_pix(mrow, mcol), 1, 0);
    chk("soft_pos", FmW'(mrow*IMG_W + mcol), FmW'(0));
    step(0, '0, 0, 0);
    obs_win = 0;
    for (int i = 0; i < NPix; i++) step(1, det_pix(mrow, mcol), 0, 0);
    chk("soft_restart_count", FmW'(obs_win), FmW'(36));

    // Synchronous reset mid-frame
    for (int i = 0; i < 20; i++) step(1, det_pix(mrow, mcol), 0, 0);
    step(1, det_pix(mrow, mcol), 0, 1);
    chk("reset_fmap_zero", bus.o_ot_fmap, FmW'(0));
    obs_win = 0;
    for (int i = 0; i < NPix; i++) begin
      step($urandom_range(0, 3) != 0 ? 1'b1 : 1'b1, det_pix(mrow, mcol), 0, 0);
      if (i == 2*IMG_W + 2) chk("restart_ci2_bit144", FmW'(bus.o_ot_fmap[144 +: 8]), FmW'(128));
    end
    chk("reset_restart_count", FmW'(obs_win), FmW'(36));
    step(0, '0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
